gen_dn_timer: RTL and testbench

Programmable down-counting timer that complements the team's saturating up-counter. A start command loads a terminal count, the block decrements on each enabled cycle, and it signals expiry with a one-cycle pulse and a sticky level. It sits beside the up-counters in control paths that need timeouts, delays and periodic ticks. Supports one-shot and auto-reload modes, plus pause and abort.

---
 rtl/gen_cntr_pkg.sv | 18 +
 rtl/gen_dn_timer_prescaler.sv | 29 ++
 rtl/gen_dn_timer.sv | 130 +++++++++++++
 tb/tb_gen_dn_timer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/gen_cntr_pkg.sv
// Shared definitions for the gen_* counter family: FSM state encoding and width helper.
package gen_cntr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Smallest bit width able to encode v distinct values (at least 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(v)) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/gen_dn_timer_prescaler.sv
// Enable-gated prescaler: one-cycle tick on every PRESCALE-th enabled cycle, phase held while disabled.
module gen_dn_timer_prescaler
  import gen_cntr_pkg::*;
#(
  parameter int unsigned PRESCALE = 10
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iEn,
  input  logic iClr,
  output logic oTick
);

  localparam int unsigned PS_W = clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] r_cnt;

  assign oTick = iEn && (r_cnt == PS_LAST);

  always_ff @(posedge iClk) begin
    if (!iRst_n || iClr) begin
      r_cnt <= '0;
    end else if (iEn) begin
      r_cnt <= (r_cnt == PS_LAST) ? '0 : r_cnt + PS_W'(1);
    end
  end

endmodule

// File: rtl/gen_dn_timer.sv
// Programmable down-counting timer with one-shot/auto-reload, pause, abort and sticky done flag.
// Optional prescaled decrement enabled by defining GEN_DN_TIMER_PRESCALE_EN.
module gen_dn_timer
  import gen_cntr_pkg::*;
#(
  parameter int unsigned MAX_LOAD = 1000
`ifdef GEN_DN_TIMER_PRESCALE_EN
  , parameter int unsigned PRESCALE = 10
`endif
  , localparam int unsigned CNT_W = clog2(MAX_LOAD + 1)
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic [CNT_W-1:0] iLoadVal,
  input  logic             iAutoReload,
  input  logic             iCntEn,
  input  logic             iAbort,
  input  logic             iDoneClr,
  output logic [CNT_W-1:0] oCntr,
  output logic             oBusy,
  output logic             oDonePulse,
  output logic             oDoneLvl
);

  state_e           r_state;
  logic [CNT_W-1:0] r_cntr;
  logic [CNT_W-1:0] r_reload;
  logic             r_auto;
  logic             r_pulse;
  logic             r_lvl;

  logic [CNT_W-1:0] w_load;
  logic             w_dec;
  logic             w_start_ok;
  logic             w_expire;

  // Clamp in CNT_W+1 bits so the compare never wraps.
  assign w_load = ({1'b0, iLoadVal} > (CNT_W+1)'(MAX_LOAD)) ? CNT_W'(MAX_LOAD) : iLoadVal;

  assign w_start_ok = (r_state != ST_RUN) && iStart && !iAbort;
  assign w_expire   = (r_state == ST_RUN) && !iAbort && w_dec && (r_cntr == CNT_W'(1));

`ifdef GEN_DN_TIMER_PRESCALE_EN
  logic w_tick;
  logic w_ps_clr;

  assign w_ps_clr = w_start_ok | iAbort | w_expire;
  assign w_dec    = iCntEn & w_tick;

  gen_dn_timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iEn    (iCntEn),
    .iClr   (w_ps_clr),
    .oTick  (w_tick)
  );
`else
  assign w_dec = iCntEn;
`endif

  // Timer FSM; abort has top priority in every state.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_state  <= ST_IDLE;
      r_cntr   <= '0;
      r_reload <= '0;
      r_auto   <= 1'b0;
      r_pulse  <= 1'b0;
      r_lvl    <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      if (iDoneClr) r_lvl <= 1'b0;

      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (iAbort) begin
            r_state <= ST_IDLE;
            r_cntr  <= '0;
          end else if (w_start_ok) begin
            r_reload <= w_load;
            r_auto   <= iAutoReload;
            r_lvl    <= 1'b0;
            if (w_load != '0) begin
              r_cntr  <= w_load;
              r_state <= ST_RUN;
            end else begin
              // Zero load expires immediately and never reloads.
              r_cntr  <= '0;
              r_state <= ST_DONE;
              r_pulse <= 1'b1;
              r_lvl   <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (iAbort) begin
            r_state <= ST_IDLE;
            r_cntr  <= '0;
          end else if (w_expire) begin
            r_pulse <= 1'b1;
            r_lvl   <= 1'b1;
            if (r_auto) begin
              r_cntr <= r_reload;
            end else begin
              r_cntr  <= '0;
              r_state <= ST_DONE;
            end
          end else if (w_dec && (r_cntr > CNT_W'(1))) begin
            r_cntr <= r_cntr - CNT_W'(1);
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_cntr  <= '0;
        end
      endcase
    end
  end

  assign oCntr      = r_cntr;
  assign oBusy      = (r_state == ST_RUN);
  assign oDonePulse = r_pulse;
  assign oDoneLvl   = r_lvl;

endmodule

// File: tb/tb_gen_dn_timer.sv
// Self-checking bench for gen_dn_timer (default build): directed scenarios plus random traffic vs. a timer model.
module tb_gen_dn_timer;

  localparam int CNT_W    = 10;
  localparam int MAX_LOAD = 1000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] load_val;
  logic             auto_rl;
  logic             cnt_en;
  logic             abort;
  logic             done_clr;
  logic [CNT_W-1:0] cntr;
  logic             busy;
  logic             done_pulse;
  logic             done_lvl;

  int n_pass  = 0;
  int n_total = 0;

  // Model: "remaining ticks" view of the timer.
  int m_remaining;   // 0 when not running
  int m_period;      // reload period, 0 = one-shot
  bit m_running;
  bit m_lvl;
  bit m_pulse;

  gen_dn_timer dut (
    .iClk        (clk),
    .iRst_n      (rst_n),
    .iStart      (start),
    .iLoadVal    (load_val),
    .iAutoReload (auto_rl),
    .iCntEn      (cnt_en),
    .iAbort      (abort),
    .iDoneClr    (done_clr),
    .oCntr       (cntr),
    .oBusy       (busy),
    .oDonePulse  (done_pulse),
    .oDoneLvl    (done_lvl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Apply the inputs present at this edge to the model.
  task automatic model_edge();
    int  lim;
    bit  expired;
    expired = 1'b0;
    m_pulse = 1'b0;
    if (!rst_n) begin
      m_remaining = 0; m_period = 0; m_running = 0; m_lvl = 0;
      return;
    end
    if (abort) begin
      m_running = 0; m_remaining = 0;
    end else if (!m_running && start) begin
      lim = (int'(load_val) > MAX_LOAD) ? MAX_LOAD : int'(load_val);
      m_lvl = 0;
      if (lim == 0) begin
        expired = 1'b1;
      end else begin
        m_running   = 1;
        m_remaining = lim;
        m_period    = auto_rl ? lim : 0;
      end
    end else if (m_running && cnt_en) begin
      m_remaining = m_remaining - 1;
      if (m_remaining == 0) begin
        expired = 1'b1;
        if (m_period != 0) m_remaining = m_period;
        else m_running = 0;
      end
    end
    if (done_clr) m_lvl = 0;
    if (expired) begin
      m_pulse = 1'b1;
      m_lvl   = 1'b1;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".cntr"},  32'(cntr),       32'(m_remaining));
    chk({tag, ".busy"},  32'(busy),       32'(m_running));
    chk({tag, ".pulse"}, 32'(done_pulse), 32'(m_pulse));
    chk({tag, ".lvl"},   32'(done_lvl),   32'(m_lvl));
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; done_clr = 0; auto_rl = 0; cnt_en = 1; load_val = '0;
  endtask

  task automatic do_start(input int l, input bit ar, input string tag);
    start = 1; load_val = CNT_W'(l); auto_rl = ar;
    cyc(tag);
    start = 0; auto_rl = 0;
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    m_remaining = 0; m_period = 0; m_running = 0; m_lvl = 0; m_pulse = 0;

    // Reset state
    cyc("reset");
    chk("reset.cntr_const", 32'(cntr), 32'd0);
    rst_n = 1;
    cyc("idle");

    // One-shot L=5: 5,4,3,2,1,0 with the single pulse after edge 5
    do_start(5, 0, "os5.start");
    chk("os5.load", 32'(cntr), 32'd5);
    for (int k = 1; k <= 5; k++) cyc("os5.run");
    chk("os5.pulse_edge5", 32'(done_pulse), 32'd1);
    chk("os5.busy_done", 32'(busy), 32'd0);
    cyc("os5.after");
    chk("os5.pulse_gone", 32'(done_pulse), 32'd0);
    chk("os5.lvl_sticky", 32'(done_lvl), 32'd1);

    // Auto-reload L=3 for 12 cycles
    do_start(3, 1, "ar3.start");
    for (int k = 0; k < 12; k++) cyc("ar3.run");
    chk("ar3.busy", 32'(busy), 32'd1);
    start = 1; load_val = CNT_W'(7);
    cyc("ar3.start_in_run");
    start = 0;
    abort = 1; cyc("ar3.abort"); abort = 0;

    // L=4 with pause at 2 then abort at 1
    do_start(4, 0, "pa4.start");
    cyc("pa4.c3"); cyc("pa4.c2");
    cnt_en = 0; cyc("pa4.hold1"); cyc("pa4.hold2");
    chk("pa4.held", 32'(cntr), 32'd2);
    cnt_en = 1; cyc("pa4.c1");
    abort = 1; cyc("pa4.abort"); abort = 0;
    chk("pa4.abort_cntr", 32'(cntr), 32'd0);
    chk("pa4.abort_nopulse", 32'(done_pulse), 32'd0);

    // Clamp and zero load
    do_start(1023, 0, "clamp.1023");
    chk("clamp.1023_val", 32'(cntr), 32'd1000);
    abort = 1; cyc("clamp.ab"); abort = 0;
    do_start(1001, 1, "clamp.1001");
    abort = 1; cyc("clamp.ab2"); abort = 0;
    do_start(1000, 0, "clamp.1000");
    abort = 1; cyc("clamp.ab3"); abort = 0;
    do_start(0, 1, "zero.start");
    chk("zero.pulse", 32'(done_pulse), 32'd1);
    cyc("zero.after"); cyc("zero.after2");
    chk("zero.no_reload", 32'(busy), 32'd0);

    // Start with abort in DONE -> IDLE, no load
    start = 1; abort = 1; load_val = CNT_W'(6);
    cyc("done.start_abort");
    start = 0; abort = 0;
    cyc("done.idle");

    // DoneClr on the expiry edge loses to set; later clear works
    do_start(2, 0, "clr.start");
    cyc("clr.c1");
    done_clr = 1; cyc("clr.expiry_edge");
    chk("clr.set_wins", 32'(done_lvl), 32'd1);
    cyc("clr.cleared"); done_clr = 0;

    // Reset mid-run
    do_start(9, 1, "rst.start");
    cyc("rst.c8");
    rst_n = 0; cyc("rst.assert");
    chk("rst.busy", 32'(busy), 32'd0);
    rst_n = 1; cyc("rst.release");

    // Randomised traffic
    for (int k = 0; k < 600; k++) begin
      start    = ($urandom_range(0, 9) == 0);
      abort    = ($urandom_range(0, 39) == 0);
      done_clr = ($urandom_range(0, 9) == 0);
      cnt_en   = ($urandom_range(0, 4) != 0);
      auto_rl  = $urandom_range(0, 1) == 1;
      rst_n    = ($urandom_range(0, 199) != 0);
      load_val = ($urandom_range(0, 19) == 0) ? CNT_W'($urandom_range(990, 1023))
                                              : CNT_W'($urandom_range(0, 8));
      cyc("rand");
    end
    rst_n = 1;
    idle_inputs();
    cyc("final");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
